// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock-enable sequencer.
package cpu_clk_pkg;

  // FSM state; the numeric values are visible on the state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BURST = 2'b11
  } state_t;

  // mode_sel values; a non-NONE mode maps one-to-one onto its state.
  localparam logic [1:0] MODE_NONE  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and
// rising-edge detector. The accepted level only flips after the
// synchronised input has differed from it for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic            sync_a;
  logic            sync_b;
  logic [DB_W-1:0] stable_cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Count consecutive cycles of disagreement; accept the new level when the run is long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      if (sync_b == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DB_LAST) begin
        stable_cnt <= '0;
        level      <= sync_b;
        rise_pulse <= sync_b;
      end else begin
        stable_cnt <= stable_cnt + DB_ONE;
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable sequencer: HALT / RUN / STEP / BURST modes producing
// single-cycle cpu_ce pulses on the system clock.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int CNT_W           = 28,
  parameter int BURST_W         = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CE_CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode_sel,
  input  logic                start,
  input  logic                stop,
  input  logic [CNT_W-1:0]    div_value,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic                step_btn,
  input  logic                cpu_halt,
  output logic                cpu_ce,
  output logic [1:0]          state,
  output logic                burst_done,
  output logic [CE_CNT_W-1:0] ce_count
);

  localparam logic [CNT_W-1:0]    ONE    = CNT_W'(1);
  localparam logic [BURST_W-1:0]  B_ONE  = BURST_W'(1);

  state_t              cur_state, state_next;
  logic [CNT_W-1:0]    div_cnt, cnt_next;
  logic [CNT_W-1:0]    period, period_next;
  logic [BURST_W-1:0]  remaining, remaining_next;
  logic                ce_next, done_next;
  logic [CNT_W-1:0]    start_period;
  logic                pulse_due;
  logic                step_level, step_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk        (clk),
    .reset      (reset),
    .raw        (step_btn),
    .level      (step_level),
    .rise_pulse (step_rise)
  );

  // A period of 0 or 1 both mean "every cycle".
  assign start_period = (div_value <= ONE) ? ONE : div_value;
  assign pulse_due    = (div_cnt == period - ONE);
  assign state        = cur_state;

  // State, divider and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state  <= ST_IDLE;
      div_cnt    <= '0;
      period     <= '0;
      remaining  <= '0;
      cpu_ce     <= 1'b0;
      burst_done <= 1'b0;
      ce_count   <= '0;
    end else begin
      cur_state  <= state_next;
      div_cnt    <= cnt_next;
      period     <= period_next;
      remaining  <= remaining_next;
      cpu_ce     <= ce_next;
      burst_done <= done_next;
      ce_count   <= ce_count + CE_CNT_W'(ce_next);
    end
  end

  // Next-state, divider and pulse decisions; stop/halt override everything.
  always_comb begin
    state_next     = cur_state;
    cnt_next       = div_cnt;
    period_next    = period;
    remaining_next = remaining;
    ce_next        = 1'b0;
    done_next      = 1'b0;
    if (stop || cpu_halt) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (start && mode_sel != MODE_NONE) begin
            period_next    = start_period;
            remaining_next = burst_len;
            cnt_next       = '0;
            if (mode_sel == MODE_BURST && burst_len == '0) begin
              // Empty burst completes immediately without leaving IDLE.
              done_next = 1'b1;
            end else begin
              state_next = state_t'(mode_sel);
              // The start cycle is divider count 0, so the first pulse
              // lands exactly one period after start.
              if (mode_sel != MODE_STEP) begin
                if (start_period == ONE) begin
                  ce_next = 1'b1;
                  if (mode_sel == MODE_BURST) remaining_next = burst_len - B_ONE;
                end else begin
                  cnt_next = ONE;
                end
              end
            end
          end
        end
        ST_RUN: begin
          if (pulse_due) begin
            ce_next  = 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next = div_cnt + ONE;
          end
        end
        ST_BURST: begin
          if (remaining == '0) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (pulse_due) begin
            ce_next        = 1'b1;
            cnt_next       = '0;
            remaining_next = remaining - B_ONE;
          end else begin
            cnt_next = div_cnt + ONE;
          end
        end
        ST_STEP: begin
          // A rise is only honoured while the accepted level is high.
          ce_next = step_rise & step_level;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_cpu_clk_ctrl;

  localparam int CNT_W = 28;
  localparam int BURST_W = 8;
  localparam int DB = 4;
  localparam int CE_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] mode_sel = 2'b00;
  logic start = 1'b0, stop = 1'b0, step_btn = 1'b0, cpu_halt = 1'b0;
  logic [CNT_W-1:0] div_value = '0;
  logic [BURST_W-1:0] burst_len = '0;
  logic cpu_ce, burst_done;
  logic [1:0] state;
  logic [CE_W-1:0] ce_count;

  cpu_clk_ctrl #(.CNT_W(CNT_W), .BURST_W(BURST_W), .DEBOUNCE_CYCLES(DB), .CE_CNT_W(CE_W)) dut (
    .clk(clk), .reset(reset), .mode_sel(mode_sel), .start(start), .stop(stop),
    .div_value(div_value), .burst_len(burst_len), .step_btn(step_btn), .cpu_halt(cpu_halt),
    .cpu_ce(cpu_ce), .state(state), .burst_done(burst_done), .ce_count(ce_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit check_en = 0;

  // Behavioural model: mode, absolute cycle of the next due pulse, pulses left.
  int cur = 0;
  int m_mode, m_period, m_due, m_rem, m_count;
  bit m_ce, m_done, m_acc, m_rise;
  bit raw_q[$];
  bit win[$];
  int ce_log[$];
  int done_log[$];

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cur);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_period = 1; m_due = 0; m_rem = 0; m_count = 0;
    m_ce = 0; m_done = 0; m_acc = 0; m_rise = 0;
    raw_q.delete(); raw_q.push_back(1'b0); raw_q.push_back(1'b0);
    win.delete();
  endtask

  // Advance the model across one clock edge using the inputs of cycle cur.
  task automatic model_step();
    bit ce, done, sv, acc_next, all_flip;
    int nm;
    if (reset) begin
      model_reset();
      cur++;
      return;
    end
    ce = 0; done = 0; nm = m_mode;
    if (stop || cpu_halt) begin
      nm = 0;
    end else begin
      case (m_mode)
        0: if (start && mode_sel != 2'b00) begin
             m_period = (div_value < 2) ? 1 : int'(div_value);
             m_rem = int'(burst_len);
             m_due = cur + m_period;
             if (mode_sel == 2'b11 && burst_len == 0) done = 1;
             else begin
               nm = int'(mode_sel);
               if (nm != 2 && m_due == cur + 1) begin
                 ce = 1; m_due += m_period;
                 if (nm == 3) m_rem--;
               end
             end
           end
        1: if (m_due == cur + 1) begin ce = 1; m_due += m_period; end
        3: if (m_rem == 0) begin done = 1; nm = 0; end
           else if (m_due == cur + 1) begin ce = 1; m_due += m_period; m_rem--; end
        default: ce = m_rise;
      endcase
    end
    // Debounce: synchronised value is the button from two cycles back; the
    // accepted level flips after DB consecutive cycles of the opposite value.
    sv = raw_q.pop_front();
    raw_q.push_back(step_btn);
    win.push_back(sv);
    if (win.size() > DB) void'(win.pop_front());
    all_flip = (win.size() == DB);
    foreach (win[i]) if (win[i] == m_acc) all_flip = 0;
    acc_next = all_flip ? ~m_acc : m_acc;
    m_rise = acc_next & ~m_acc;
    m_acc = acc_next;
    m_mode = nm; m_ce = ce; m_done = done;
    m_count = (m_count + int'(ce)) % (1 << CE_W);
    cur++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    ce_log.delete(); done_log.delete();
  endtask

  // Compare every cycle, half a period after the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("state", state, m_mode);
      check("cpu_ce", cpu_ce, m_ce);
      check("burst_done", burst_done, m_done);
      check("ce_count", ce_count, m_count);
      if (cpu_ce) ce_log.push_back(cur);
      if (burst_done) done_log.push_back(cur);
    end
  end

  int t0;
  int exp1[3] = '{5, 10, 15};
  int exp2[4] = '{3, 6, 9, 12};

  initial begin
    model_reset();
    check_en = 1;
    do_reset();

    // RUN, period 5, stop at cycle 17
    t0 = cur; mode_sel = 2'b01; div_value = 5; start = 1; tick(); start = 0;
    repeat (16) tick();
    stop = 1; tick(); stop = 0;
    check("run_state_after_stop", state, 0);
    check("run_ce_count", ce_count, 3);
    repeat (10) tick();
    check("run_pulse_total", ce_log.size(), 3);
    for (int i = 0; i < 3 && i < ce_log.size(); i++) check("run_pulse_cycle", ce_log[i] - t0, exp1[i]);
    $display("txn run_div5: pulses=%0d ce_count=%0d", ce_log.size(), ce_count);

    // BURST, period 3, length 4
    do_reset();
    t0 = cur; mode_sel = 2'b11; div_value = 3; burst_len = 4; start = 1; tick(); start = 0;
    repeat (15) tick();
    check("burst_pulse_total", ce_log.size(), 4);
    for (int i = 0; i < 4 && i < ce_log.size(); i++) check("burst_pulse_cycle", ce_log[i] - t0, exp2[i]);
    check("burst_done_total", done_log.size(), 1);
    if (done_log.size() > 0) check("burst_done_cycle", done_log[0] - t0, 13);
    check("burst_ce_count", ce_count, 4);
    check("burst_state_idle", state, 0);
    $display("txn burst_len4: pulses=%0d done=%0d", ce_log.size(), done_log.size());

    // BURST, length 0
    ce_log.delete(); done_log.delete();
    t0 = cur; burst_len = 0; start = 1; tick(); start = 0;
    check("burst0_done_now", burst_done, 1);
    check("burst0_state", state, 0);
    repeat (5) tick();
    check("burst0_no_ce", ce_log.size(), 0);
    check("burst0_done_total", done_log.size(), 1);
    $display("txn burst_len0: done=%0d pulses=%0d", done_log.size(), ce_log.size());

    // STEP: bouncy press, hold, release; then a short glitch
    do_reset();
    mode_sel = 2'b10; start = 1; tick(); start = 0;
    check("step_state", state, 2);
    step_btn = 1; tick(); step_btn = 0; tick(); step_btn = 1; tick();
    repeat (20) tick();
    step_btn = 0; repeat (20) tick();
    check("step_one_pulse", ce_log.size(), 1);
    ce_log.delete();
    step_btn = 1; repeat (2) tick(); step_btn = 0; repeat (20) tick();
    check("step_glitch_none", ce_log.size(), 0);
    $display("txn step: glitch pulses=%0d", ce_log.size());

    // RUN every cycle, halted at cycle 6, start under halt ignored
    do_reset();
    t0 = cur; mode_sel = 2'b01; div_value = 0; start = 1; tick(); start = 0;
    repeat (5) tick();
    cpu_halt = 1; tick();
    check("halt_ce_off", cpu_ce, 0);
    check("halt_state", state, 0);
    start = 1; tick(); start = 0; tick(); cpu_halt = 0;
    repeat (3) tick();
    check("halt_state_after_start", state, 0);
    check("halt_pulse_total", ce_log.size(), 6);
    for (int i = 0; i < 6 && i < ce_log.size(); i++) check("halt_pulse_cycle", ce_log[i] - t0, i + 1);
    $display("txn run_div0_halt: pulses=%0d", ce_log.size());

    // BURST aborted by reset after 3 pulses
    do_reset();
    mode_sel = 2'b11; div_value = 2; burst_len = 10; start = 1; tick(); start = 0;
    repeat (6) tick();
    check("abort_ce_count_before", ce_count, 3);
    reset = 1; model_reset(); #1;
    check("abort_cpu_ce", cpu_ce, 0);
    check("abort_state", state, 0);
    check("abort_ce_count", ce_count, 0);
    check("abort_done", burst_done, 0);
    tick(); tick(); reset = 0;
    repeat (25) tick();
    check("abort_no_done", done_log.size(), 0);
    $display("txn burst_abort: done=%0d", done_log.size());

    // start and stop together
    ce_log.delete();
    mode_sel = 2'b01; div_value = 2; start = 1; stop = 1; tick(); start = 0; stop = 0;
    check("startstop_state", state, 0);
    repeat (6) tick();
    check("startstop_no_ce", ce_log.size(), 0);
    $display("txn start_stop: state=%0d", state);

    // ce_count wrap
    do_reset();
    mode_sel = 2'b01; div_value = 1; start = 1; tick(); start = 0;
    repeat (16) tick();
    check("wrap_ce_count", ce_count, 1);
    stop = 1; tick(); stop = 0; tick();
    check("wrap_pulse_total", ce_log.size(), 17);
    $display("txn wrap: ce_count=%0d", ce_count);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 11) == 0);
      mode_sel = 2'($urandom_range(0, 3));
      div_value = CNT_W'($urandom_range(0, 6));
      burst_len = BURST_W'($urandom_range(0, 5));
      stop = ($urandom_range(0, 63) == 0);
      cpu_halt = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
      tick();
    end
    start = 0; stop = 0; cpu_halt = 0;
    tick();
    $display("txn random: pulses=%0d bursts=%0d", ce_log.size(), done_log.size());

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
